// File: rtl/master_req_queue.sv
// Per-master show-ahead request FIFO feeding the crossbar arbiter; capture at edge, head visible next cycle (q_req rises with s_ack).
// Backpressure: a held s_req is not accepted while full; accepts are at most one per two cycles.
module master_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_req,
    input  logic                     s_cmd,
    input  logic [ADDR_W-1:0]        s_addr,
    input  logic [DATA_W-1:0]        s_wdata,
    output logic                     s_ack,
    output logic                     q_req,
    output logic                     q_cmd,
    output logic [ADDR_W-1:0]        q_addr,
    output logic [DATA_W-1:0]        q_wdata,
    input  logic                     q_rd_en,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     pop_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef struct packed {
        logic              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          pop_err_q, pop_err_d;
    logic          wr_en;
    logic          empty;
    logic          full;
    entry_t        mem [DEPTH];
    entry_t        head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

    // Full is taken from registered pointers, so a pop in the same cycle does not open a slot until the next one.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_err_d = pop_err_q;
        case (state_q)
            IDLE: begin
                if (s_req && !full) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    state_d  = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (q_rd_en) begin
            if (empty) begin
                pop_err_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pop_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pop_err_q <= pop_err_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[IW-1:0]] <= '{cmd: s_cmd, addr: s_addr, wdata: s_wdata};
        end
    end

    assign head    = mem[rd_ptr_q[IW-1:0]];
    assign s_ack   = (state_q == ACK);
    assign q_req   = !empty;
    assign q_cmd   = empty ? 1'b0 : head.cmd;
    assign q_addr  = empty ? '0 : head.addr;
    assign q_wdata = empty ? '0 : head.wdata;
    assign q_count = wr_ptr_q - rd_ptr_q;
    assign q_full  = full;
    assign pop_err = pop_err_q;

endmodule

// File: tb/tb_master_req_queue.sv
// Directed bench for master_req_queue at DEPTH=4; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_master_req_queue;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_req;
    logic        s_cmd;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ack;
    logic        q_req;
    logic        q_cmd;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic        q_rd_en;
    logic [2:0]  q_count;
    logic        q_full;
    logic        pop_err;

    int checks = 0;
    int errors = 0;

    master_req_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_req   (s_req),
        .s_cmd   (s_cmd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .q_req   (q_req),
        .q_cmd   (q_cmd),
        .q_addr  (q_addr),
        .q_wdata (q_wdata),
        .q_rd_en (q_rd_en),
        .q_count (q_count),
        .q_full  (q_full),
        .pop_err (pop_err)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic cmd, input logic [31:0] addr, input logic [31:0] data);
        int n;
        s_req   = 1'b1;
        s_cmd   = cmd;
        s_addr  = addr;
        s_wdata = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_ack !== 1'b1 && n < 50);
        checks++;
        if (s_ack !== 1'b1) begin
            errors++;
            $display("FAIL push_ack_timeout: s_ack=%b required 1 (addr %h)", s_ack, addr);
        end
        s_req = 1'b0;
    endtask

    task automatic pop();
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        areset  = 1'b1;
        s_req   = 1'b0;
        s_cmd   = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        q_rd_en = 1'b0;
        #2;
        checks++;
        if ({s_ack, q_req, q_cmd, q_full, pop_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: {ack,req,cmd,full,err}=%b required 00000", {s_ack, q_req, q_cmd, q_full, pop_err});
        end
        checks++;
        if (q_count !== 3'd0 || q_addr !== 32'h0 || q_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: count=%0d addr=%h wdata=%h required 0/0/0", q_count, q_addr, q_wdata);
        end
        #10;
        areset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        s_req   = 1'b1;
        s_cmd   = 1'b1;
        s_addr  = 32'h10;
        s_wdata = 32'hDEAD;
        checks++;
        if (s_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_early: s_ack=%b required 0", s_ack);
        end
        tick();
        checks++;
        if (s_ack !== 1'b1 || q_req !== 1'b1 || q_cmd !== 1'b1) begin
            errors++;
            $display("FAIL single_flags: ack=%b req=%b cmd=%b required 1/1/1", s_ack, q_req, q_cmd);
        end
        checks++;
        if (q_addr !== 32'h10 || q_wdata !== 32'hDEAD || q_count !== 3'd1) begin
            errors++;
            $display("FAIL single_head: addr=%h wdata=%h count=%0d required 10/dead/1", q_addr, q_wdata, q_count);
        end
        s_req = 1'b0;
        tick();
        checks++;
        if (s_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_width: s_ack=%b required 0", s_ack);
        end
        pop();
        checks++;
        if (q_req !== 1'b0 || q_count !== 3'd0 || q_addr !== 32'h0) begin
            errors++;
            $display("FAIL single_drain: req=%b count=%0d addr=%h required 0/0/0", q_req, q_count, q_addr);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push(1'b0, i, 32'h0);
        checks++;
        if (q_full !== 1'b1 || q_count !== 3'd4 || q_addr !== 32'h0) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d head=%h required 1/4/0", q_full, q_count, q_addr);
        end
        s_req  = 1'b1;
        s_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (s_ack !== 1'b0 || q_count !== 3'd4) begin
                errors++;
                $display("FAIL fill_stall cycle %0d: ack=%b count=%0d required 0/4", i, s_ack, q_count);
            end
        end
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        checks++;
        if (s_ack !== 1'b0 || q_count !== 3'd3 || q_addr !== 32'h1) begin
            errors++;
            $display("FAIL fill_pop_edge: ack=%b count=%0d head=%h required 0/3/1", s_ack, q_count, q_addr);
        end
        tick();
        checks++;
        if (s_ack !== 1'b1 || q_count !== 3'd4 || q_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_refill: ack=%b count=%0d full=%b required 1/4/1", s_ack, q_count, q_full);
        end
        s_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (q_addr !== 32'(i) || q_cmd !== 1'b0) begin
                errors++;
                $display("FAIL fill_order %0d: head=%h cmd=%b required %h/0", i, q_addr, q_cmd, i);
            end
            pop();
        end
        checks++;
        if (q_req !== 1'b0 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty: req=%b count=%0d required 0/0", q_req, q_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            push(i[0], 32'h100 + i, 32'hA000 + i);
            checks++;
            if (q_addr !== 32'h100 + i || q_wdata !== 32'hA000 + i || q_count !== 3'd1) begin
                errors++;
                $display("FAIL wrap_head %0d: addr=%h wdata=%h count=%0d required %h/%h/1",
                         i, q_addr, q_wdata, q_count, 32'h100 + i, 32'hA000 + i);
            end
            pop();
            checks++;
            if (q_count !== 3'd0) begin
                errors++;
                $display("FAIL wrap_count %0d: count=%0d required 0", i, q_count);
            end
        end
    endtask

    task automatic test_simultaneous();
        push(1'b0, 32'hA, 32'h0);
        push(1'b1, 32'hB, 32'hBB);
        s_req  = 1'b1;
        s_cmd  = 1'b0;
        s_addr = 32'hC;
        tick();
        checks++;
        if (q_count !== 3'd2 || q_addr !== 32'hA || s_ack !== 1'b0) begin
            errors++;
            $display("FAIL simul_pre: count=%0d head=%h ack=%b required 2/a/0", q_count, q_addr, s_ack);
        end
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        s_req   = 1'b0;
        checks++;
        if (s_ack !== 1'b1 || q_count !== 3'd2 || q_addr !== 32'hB || q_cmd !== 1'b1) begin
            errors++;
            $display("FAIL simul_both: ack=%b count=%0d head=%h cmd=%b required 1/2/b/1", s_ack, q_count, q_addr, q_cmd);
        end
        pop();
        checks++;
        if (q_addr !== 32'hC || q_count !== 3'd1) begin
            errors++;
            $display("FAIL simul_next: head=%h count=%0d required c/1", q_addr, q_count);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [4:0] ack_seen;
        tick();
        s_req  = 1'b1;
        s_cmd  = 1'b1;
        s_addr = 32'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            ack_seen[i] = s_ack;
        end
        s_req = 1'b0;
        checks++;
        if (ack_seen !== 5'b10101) begin
            errors++;
            $display("FAIL b2b_ack_pattern: got %b required 10101", ack_seen);
        end
        checks++;
        if (q_count !== 3'd3) begin
            errors++;
            $display("FAIL b2b_count: count=%0d required 3", q_count);
        end
        for (int i = 0; i < 3; i++) pop();
    endtask

    task automatic test_pop_err();
        pop();
        checks++;
        if (pop_err !== 1'b1 || q_count !== 3'd0 || q_req !== 1'b0) begin
            errors++;
            $display("FAIL poperr_set: err=%b count=%0d req=%b required 1/0/0", pop_err, q_count, q_req);
        end
        push(1'b1, 32'h55, 32'h1234);
        checks++;
        if (q_addr !== 32'h55 || q_wdata !== 32'h1234 || q_count !== 3'd1 || pop_err !== 1'b1) begin
            errors++;
            $display("FAIL poperr_sticky: addr=%h wdata=%h count=%0d err=%b required 55/1234/1/1",
                     q_addr, q_wdata, q_count, pop_err);
        end
        tick();
        #2;
        areset = 1'b1;
        #1;
        checks++;
        if (pop_err !== 1'b0 || q_count !== 3'd0 || q_req !== 1'b0) begin
            errors++;
            $display("FAIL poperr_clear: err=%b count=%0d req=%b required 0/0/0", pop_err, q_count, q_req);
        end
        #4;
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        s_req   = 1'b1;
        s_cmd   = 1'b1;
        s_addr  = 32'h99;
        s_wdata = 32'h9;
        tick();
        checks++;
        if (s_ack !== 1'b1 || q_count !== 3'd1) begin
            errors++;
            $display("FAIL midrst_pre: ack=%b count=%0d required 1/1", s_ack, q_count);
        end
        s_req = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        checks++;
        if (s_ack !== 1'b0 || q_req !== 1'b0 || q_count !== 3'd0 || q_addr !== 32'h0) begin
            errors++;
            $display("FAIL midrst_clear: ack=%b req=%b count=%0d addr=%h required 0/0/0/0", s_ack, q_req, q_count, q_addr);
        end
        #3;
        areset = 1'b0;
        tick();
        checks++;
        if (s_ack !== 1'b0 || q_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: ack=%b req=%b required 0/0", s_ack, q_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_back_to_back();
        test_pop_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
